// File: rtl/bufg_div_multi.sv
// Multi-channel runtime-programmable clock divider (simulation model of a BUFG divider).
// Each channel divides I by D+1, reloads D only at period boundaries, and emits a strobe per rising edge.
module bufg_div_multi #(
  parameter int NUM_CH         = 2,
  parameter int DIV_W          = 4,
  parameter int DIV_RESET      = 1,
  parameter int CE_SYNC_STAGES = 2
) (
  input  logic                      I,
  input  logic                      CLR_N,
  input  logic [NUM_CH-1:0]         CE,
  input  logic [NUM_CH*DIV_W-1:0]   DIV,
  input  logic [NUM_CH-1:0]         DIV_WE,
  input  logic                      SYNC,
  output logic [NUM_CH-1:0]         O,
  output logic [NUM_CH-1:0]         STB,
  output logic [NUM_CH-1:0]         BUSY
);

  localparam int SD = (CE_SYNC_STAGES == 0) ? 1 : CE_SYNC_STAGES;
  localparam logic [DIV_W-1:0] D_RST = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [NUM_CH-1:0] ce_pipe_q [SD];
  logic [NUM_CH-1:0] ce_s;

  always_ff @(posedge I or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int s = 0; s < SD; s++) ce_pipe_q[s] <= '0;
    end else begin
      ce_pipe_q[0] <= CE;
      for (int s = 1; s < SD; s++) ce_pipe_q[s] <= ce_pipe_q[s-1];
    end
  end

  // With zero stages the pipe still exists but is bypassed.
  assign ce_s = (CE_SYNC_STAGES == 0) ? CE : ce_pipe_q[SD-1];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] d_act_q, d_act_d;
    logic [DIV_W-1:0] d_pend_q, d_pend_d;
    logic [DIV_W-1:0] field;
    logic [DIV_W-1:0] h;
    logic [DIV_W:0]   n;
    logic             o_q, o_d;
    logic             stb_q, stb_d;
    logic             en_q;
    logic             bypass;
    logic             run;

    assign field  = DIV[k*DIV_W +: DIV_W];
    assign n      = {1'b0, d_act_q} + {{DIV_W{1'b0}}, 1'b1};
    assign h      = n[DIV_W:1];
    assign bypass = (d_act_q == '0);

    always_comb begin
      run      = ce_s[k] | (cnt_q != '0);
      cnt_d    = cnt_q;
      d_act_d  = d_act_q;
      d_pend_d = d_pend_q;
      o_d      = o_q;
      stb_d    = stb_q;
      if (SYNC) begin
        cnt_d    = '0;
        o_d      = 1'b0;
        stb_d    = 1'b0;
        d_act_d  = DIV_WE[k] ? field : d_pend_q;
        d_pend_d = d_act_d;
      end else begin
        if (!run || (cnt_q == d_act_q)) cnt_d = '0;
        else                            cnt_d = cnt_q + ONE;
        // Reload uses the pending value from before this edge's write.
        if (cnt_d == '0) d_act_d = d_pend_q;
        if (DIV_WE[k]) d_pend_d = field;
        o_d   = !bypass && (cnt_d >= h);
        stb_d = !bypass && (cnt_d == h);
      end
    end

    always_ff @(posedge I or negedge CLR_N) begin
      if (!CLR_N) begin
        cnt_q    <= '0;
        d_act_q  <= D_RST;
        d_pend_q <= D_RST;
        o_q      <= 1'b0;
        stb_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        d_act_q  <= d_act_d;
        d_pend_q <= d_pend_d;
        o_q      <= o_d;
        stb_q    <= stb_d;
      end
    end

    // Gate changes only while I is low, so the pass-through clock never glitches.
    always_ff @(negedge I or negedge CLR_N) begin
      if (!CLR_N) en_q <= 1'b0;
      else        en_q <= bypass & ce_s[k];
    end

    assign O[k]    = bypass ? (I & en_q) : o_q;
    assign STB[k]  = bypass ? en_q : stb_q;
    assign BUSY[k] = (d_pend_q != d_act_q);
  end

endmodule

// File: tb/tb_bufg_div_multi.sv
// Directed bench for bufg_div_multi: two channels, default parameters, hand-derived waveforms.
module tb_bufg_div_multi;
  logic       I;
  logic       CLR_N;
  logic [1:0] CE;
  logic [7:0] DIV;
  logic [1:0] DIV_WE;
  logic       SYNC;
  logic [1:0] O;
  logic [1:0] STB;
  logic [1:0] BUSY;

  int tests;
  int fails;

  bufg_div_multi dut (
    .I(I), .CLR_N(CLR_N), .CE(CE), .DIV(DIV), .DIV_WE(DIV_WE),
    .SYNC(SYNC), .O(O), .STB(STB), .BUSY(BUSY)
  );

  initial begin
    I = 1'b0;
    forever #5 I = ~I;
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one posedge of I, then check all outputs (bit 1 = ch1, bit 0 = ch0).
  task automatic step_chk(input string tag, input logic [1:0] eo, input logic [1:0] es,
                          input logic [1:0] eb);
    @(posedge I);
    #1;
    chk({tag, ".O"}, O, eo);
    chk({tag, ".STB"}, STB, es);
    chk({tag, ".BUSY"}, BUSY, eb);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    CLR_N  = 1'b0;
    CE     = 2'b00;
    DIV    = 8'h00;
    DIV_WE = 2'b00;
    SYNC   = 1'b0;

    step_chk("rst0", 2'b00, 2'b00, 2'b00);
    step_chk("rst1", 2'b00, 2'b00, 2'b00);
    CLR_N = 1'b1;
    step_chk("idle0", 2'b00, 2'b00, 2'b00);
    step_chk("idle1", 2'b00, 2'b00, 2'b00);

    // Default divide-by-2 after CE crosses the synchroniser.
    CE = 2'b11;
    step_chk("cesync0", 2'b00, 2'b00, 2'b00);
    step_chk("cesync1", 2'b00, 2'b00, 2'b00);
    step_chk("div2_a", 2'b11, 2'b11, 2'b00);
    step_chk("div2_b", 2'b00, 2'b00, 2'b00);
    step_chk("div2_c", 2'b11, 2'b11, 2'b00);

    // Write ch0 D=3 on a wrap edge: deferred to the following boundary.
    DIV = {4'd1, 4'd3}; DIV_WE = 2'b01;
    step_chk("we_wrap", 2'b00, 2'b00, 2'b01);
    DIV_WE = 2'b00;
    step_chk("busy_hold", 2'b11, 2'b11, 2'b01);
    step_chk("reload4", 2'b00, 2'b00, 2'b00);
    step_chk("div4_c1", 2'b10, 2'b10, 2'b00);
    step_chk("div4_c2", 2'b01, 2'b01, 2'b00);
    step_chk("div4_c3", 2'b11, 2'b10, 2'b00);
    step_chk("div4_c0", 2'b00, 2'b00, 2'b00);
    step_chk("div4_c1b", 2'b10, 2'b10, 2'b00);

    // At ch0 cnt=1, switch to divide-by-2: the current period must finish first.
    DIV = {4'd1, 4'd1}; DIV_WE = 2'b01;
    step_chk("mid_c2", 2'b01, 2'b01, 2'b01);
    DIV_WE = 2'b00;
    step_chk("mid_c3", 2'b11, 2'b10, 2'b01);
    step_chk("mid_wrap", 2'b00, 2'b00, 2'b00);
    step_chk("new2_a", 2'b11, 2'b11, 2'b00);
    step_chk("new2_b", 2'b00, 2'b00, 2'b00);

    // ch0 divide-by-3, ch1 divide-by-5.
    DIV = {4'd4, 4'd2}; DIV_WE = 2'b11;
    step_chk("w35", 2'b11, 2'b11, 2'b11);
    DIV_WE = 2'b00;
    step_chk("r35", 2'b00, 2'b00, 2'b00);
    step_chk("d35_1", 2'b01, 2'b01, 2'b00);
    step_chk("d35_2", 2'b11, 2'b10, 2'b00);
    step_chk("d35_3", 2'b10, 2'b00, 2'b00);
    step_chk("d35_4", 2'b11, 2'b01, 2'b00);
    step_chk("d35_5", 2'b01, 2'b00, 2'b00);
    step_chk("d35_6", 2'b00, 2'b00, 2'b00);

    // SYNC with same-edge writes: ch0 divide-by-2, ch1 divide-by-4.
    DIV = {4'd3, 4'd1}; DIV_WE = 2'b11; SYNC = 1'b1;
    step_chk("sync", 2'b00, 2'b00, 2'b00);
    DIV_WE = 2'b00; SYNC = 1'b0;
    step_chk("sync_1", 2'b01, 2'b01, 2'b00);
    step_chk("sync_2", 2'b10, 2'b10, 2'b00);
    step_chk("sync_3", 2'b11, 2'b01, 2'b00);
    step_chk("sync_4", 2'b00, 2'b00, 2'b00);
    step_chk("sync_5", 2'b01, 2'b01, 2'b00);

    // Drop CE at ch1 cnt=1: two synchroniser edges, then periods complete and idle.
    CE = 2'b00;
    step_chk("cedrop_1", 2'b10, 2'b10, 2'b00);
    step_chk("cedrop_2", 2'b11, 2'b01, 2'b00);
    step_chk("cedrop_3", 2'b00, 2'b00, 2'b00);
    step_chk("cedrop_4", 2'b00, 2'b00, 2'b00);

    // Idle channel reloads on every edge.
    DIV = {4'd1, 4'd1}; DIV_WE = 2'b10;
    step_chk("idle_we", 2'b00, 2'b00, 2'b10);
    DIV_WE = 2'b00;
    step_chk("idle_rl", 2'b00, 2'b00, 2'b00);

    // ch0 divide-by-1: pass-through gated by the negedge enable flop.
    DIV = {4'd1, 4'd0}; DIV_WE = 2'b01;
    step_chk("by1_we", 2'b00, 2'b00, 2'b01);
    DIV_WE = 2'b00;
    step_chk("by1_rl", 2'b00, 2'b00, 2'b00);
    CE = 2'b01;
    step_chk("by1_ce0", 2'b00, 2'b00, 2'b00);
    step_chk("by1_ce1", 2'b00, 2'b00, 2'b00);
    step_chk("by1_hi", 2'b01, 2'b01, 2'b00);
    @(negedge I);
    #1;
    chk("by1_lo.O", O, 2'b00);
    chk("by1_lo.STB", STB, 2'b01);
    CE = 2'b00;
    step_chk("by1_off0", 2'b01, 2'b01, 2'b00);
    step_chk("by1_off1", 2'b01, 2'b01, 2'b00);
    step_chk("by1_off2", 2'b00, 2'b00, 2'b00);
    step_chk("by1_off3", 2'b00, 2'b00, 2'b00);

    // Asynchronous reset mid-cycle restores defaults immediately.
    DIV = {4'd5, 4'd5}; DIV_WE = 2'b11;
    step_chk("pre_rst", 2'b00, 2'b00, 2'b11);
    DIV_WE = 2'b00;
    #2;
    CLR_N = 1'b0;
    #1;
    chk("arst.O", O, 2'b00);
    chk("arst.STB", STB, 2'b00);
    chk("arst.BUSY", BUSY, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
